dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 35 +++
 rtl/dmem_responder_tx_fifo.sv | 48 ++++
 rtl/dmem_responder.sv | 101 ++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - register map, STATUS layout and address decode shared by the responder
package dmem_responder_pkg;

  localparam logic [31:0] TXDATA_OFF = 32'h0;
  localparam logic [31:0] STATUS_OFF = 32'h4;
  localparam logic [31:0] CYCLE_OFF  = 32'h8;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 4;
  localparam int STATUS_COUNT_MSB = 8;

  typedef enum logic [2:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_TXDATA,
    REGION_STATUS,
    REGION_CYCLE
  } region_e;

  // RAM wins if the register window were ever placed inside the RAM range.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [31:0] mmio_base);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    if (addr < ram_bytes)                          return REGION_RAM;
    else if (word_addr == mmio_base + TXDATA_OFF)  return REGION_TXDATA;
    else if (word_addr == mmio_base + STATUS_OFF)  return REGION_STATUS;
    else if (word_addr == mmio_base + CYCLE_OFF)   return REGION_CYCLE;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// rtl/dmem_responder_tx_fifo.sv - byte TX FIFO with registered head, no bypass path
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = storage[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push && !reset) storage[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - zero-latency data RAM plus TXDATA/STATUS/CYCLE register window
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  region_e          region;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      mem [MEM_WORDS];
  logic [31:0]      cycle_q;
  logic             overflow_q;
  logic [31:0]      status_word;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_head;

  assign region    = decode_region(address, RAM_BYTES, MMIO_BASE);
  assign word_idx  = address[IDX_W+1:2];
  assign fifo_push = store && (region == REGION_TXDATA);
  assign fifo_pop  = !fifo_empty && tx_ready;
  assign tx_valid  = !fifo_empty;
  assign tx_data   = fifo_head;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data (store_data[7:0]),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // RAM contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (store && (region == REGION_RAM)) mem[word_idx] <= store_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (store && (region == REGION_CYCLE)) cycle_q <= store_data;
      else                                   cycle_q <= cycle_q + 32'd1;

      if (store && (region == REGION_STATUS) && store_data[STATUS_OVF_BIT])
        overflow_q <= 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop)
        overflow_q <= 1'b1;
    end
  end

  always_comb begin
    status_word                                    = '0;
    status_word[STATUS_EMPTY_BIT]                  = fifo_empty;
    status_word[STATUS_FULL_BIT]                   = fifo_full;
    status_word[STATUS_OVF_BIT]                    = overflow_q;
    status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 5'(fifo_count);
  end

  always_comb begin
    load_data = '0;
    if (load) begin
      case (region)
        REGION_RAM:    load_data = mem[word_idx];
        REGION_STATUS: load_data = status_word;
        REGION_CYCLE:  load_data = cycle_q;
        default:       load_data = '0;
      endcase
    end
  end

endmodule
